id_ex_register: RTL
===================

# id_ex_register

ID/EX pipeline register of the five-stage RISC-V core. It captures the hazard-gated control bundle from the ID-stage control multiplexer, together with the decoded operands, and presents them to EX. It also produces the load-use hazard strobe that gates that multiplexer and stalls IF/ID. A saturating bubble counter is included for performance monitoring.

## Interface
- XLEN, 32, datapath width (PC, operands, immediate)
- CNT_W, 16, bubble counter width
- clk_i  in  1  core clock; all state updates on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- stall_i  in  1  hold all state (back-pressure from EX/MEM)
- flush_i  in  1  replace entry with bubble (branch/jump redirect)
- id_valid_i  in  1  ID holds a real instruction
- pc_i, rs1_data_i, rs2_data_i, imm_i  in  XLEN each  decoded operands
- rs1_addr_i, rs2_addr_i  in  5  source register indices of the instruction in ID
- funct_i  in  10  {funct7, funct3}
- RegDst_i  in  5; ALUOp_i  in  2; ALUSrc_i, RegWrite_i, MemToReg_i, MemRead_i, MemWrite_i  in  1  gated control bundle
- cnt_clr_i  in  1  synchronous clear of bubble counter
- ex_* outputs, one per data/control input above  out  same widths  registered EX-stage copies
- ex_rs1_addr_o, ex_rs2_addr_o  out  5  for the forwarding unit
- ex_valid_o  out  1  EX entry is a real instruction
- hazard_o  out  1  load-use hazard; drives Hazard_i of the control mux and the IF/ID/PC stall
- bubble_cnt_o  out  CNT_W  bubbles inserted since reset/clear

## Operation
- Per-cycle action priority: reset > flush_i > stall_i > load.
- Reset (rst_n_i low, asynchronous): every ex_* output, ex_valid_o, and bubble_cnt_o is set to 0. hazard_o is therefore 0.
- Flush: all ex_* data and control outputs are set to 0 and ex_valid_o is set to 0. This applies even if stall_i is high.
- Stall (no flush): all ex_* outputs and ex_valid_o hold their values.
- Load: every ex_* output takes its corresponding input, and ex_valid_o takes id_valid_i & ~hazard_o.
  - Control outputs are loaded as presented. They are already zero during a hazard because the mux zeroes them.
- hazard_o is combinational from registered state and current ID inputs:
  - hazard_o = ex_valid_o & ex_MemRead_o & (ex_RegDst_o != 0) & ((ex_RegDst_o == rs1_addr_i) | (ex_RegDst_o == rs2_addr_i)).
  - A destination of x0 never raises a hazard.
  - hazard_o is not gated by stall_i or flush_i.
- Bubble counter increments by 1 on a clock edge where either:
  - flush_i = 1, or
  - a load occurs with hazard_o = 1.
- Bubble counter rules:
  - It saturates at 2^CNT_W−1 and does not wrap.
  - cnt_clr_i sets it to 0 and takes priority over an increment in the same cycle.
  - It is unaffected by stall_i when no flush occurs.

## Timing
- Latency: one cycle from ID inputs to ex_* outputs.
- hazard_o is valid in the same cycle as the rs addresses it compares; there is no registered delay.
- A load-use pair produces exactly one bubble:
  - Cycle N: the load is in EX and the dependent instruction is in ID, so hazard_o = 1.
  - Edge N+1: a bubble is captured.
  - Cycle N+1: ex_valid_o = 0 and ex_MemRead_o = 0, so hazard_o = 0 and the dependent instruction advances on the next edge.
- Reset deassertion mid-stream: the first edge after release performs a normal load.

## Test plan
- Reset: hold rst_n_i low with random inputs.
  - Required: all ex_* outputs = 0, ex_valid_o = 0, bubble_cnt_o = 0, hazard_o = 0.
  - Asserting reset between edges must clear the outputs immediately.
- Plain load: id_valid_i = 1, pc_i = 0x100, RegDst_i = 5, RegWrite_i = 1.
  - Required next cycle: ex_pc_o = 0x100, ex_RegDst_o = 5, ex_RegWrite_o = 1, ex_valid_o = 1.
- Load-use: lw x5 loaded into EX (ex_MemRead_o = 1, ex_RegDst_o = 5), then ID presents rs1_addr_i = 5 with zeroed controls.
  - Required: hazard_o = 1 in that cycle, ex_valid_o = 0 on the next cycle, bubble_cnt_o increments by 1, hazard_o returns to 0.
  - Repeat with ex_RegDst_o = 0: hazard_o must stay 0.
- Stall plus flush: with a valid entry held, assert stall_i for 3 cycles.
  - Required: outputs unchanged and bubble_cnt_o unchanged.
  - Then assert stall_i and flush_i together: ex_valid_o = 0, all controls = 0, bubble_cnt_o increments by 1.
- Counter saturation: with CNT_W = 4, apply 20 consecutive flushes.
  - Required: bubble_cnt_o stops at 15.
  - Then apply cnt_clr_i together with flush_i: bubble_cnt_o = 0.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures gated control and decoded operands for EX,
// detects load-use hazards against the ID-stage sources, and counts inserted bubbles.
module id_ex_register #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [9:0]        funct_i,
  input  logic [4:0]        RegDst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemToReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              cnt_clr_i,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [4:0]        ex_rs1_addr_o,
  output logic [4:0]        ex_rs2_addr_o,
  output logic [9:0]        ex_funct_o,
  output logic [4:0]        ex_RegDst_o,
  output logic [1:0]        ex_ALUOp_o,
  output logic              ex_ALUSrc_o,
  output logic              ex_RegWrite_o,
  output logic              ex_MemToReg_o,
  output logic              ex_MemRead_o,
  output logic              ex_MemWrite_o,
  output logic              ex_valid_o,
  output logic              hazard_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic bubble_evt;

  // A load in EX whose destination matches either ID source forces one bubble; x0 is exempt.
  assign hazard_o = ex_valid_o & ex_MemRead_o & (ex_RegDst_o != 5'd0) &
                    ((ex_RegDst_o == rs1_addr_i) | (ex_RegDst_o == rs2_addr_i));

  assign bubble_evt = flush_i | (~stall_i & hazard_o);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_funct_o    <= '0;
      ex_RegDst_o   <= '0;
      ex_ALUOp_o    <= '0;
      ex_ALUSrc_o   <= 1'b0;
      ex_RegWrite_o <= 1'b0;
      ex_MemToReg_o <= 1'b0;
      ex_MemRead_o  <= 1'b0;
      ex_MemWrite_o <= 1'b0;
      ex_valid_o    <= 1'b0;
    end else if (flush_i) begin
      ex_pc_o       <= '0;
      ex_rs1_data_o <= '0;
      ex_rs2_data_o <= '0;
      ex_imm_o      <= '0;
      ex_rs1_addr_o <= '0;
      ex_rs2_addr_o <= '0;
      ex_funct_o    <= '0;
      ex_RegDst_o   <= '0;
      ex_ALUOp_o    <= '0;
      ex_ALUSrc_o   <= 1'b0;
      ex_RegWrite_o <= 1'b0;
      ex_MemToReg_o <= 1'b0;
      ex_MemRead_o  <= 1'b0;
      ex_MemWrite_o <= 1'b0;
      ex_valid_o    <= 1'b0;
    end else if (!stall_i) begin
      // Controls arrive already zeroed by the ID mux during a hazard; only valid needs gating.
      ex_pc_o       <= pc_i;
      ex_rs1_data_o <= rs1_data_i;
      ex_rs2_data_o <= rs2_data_i;
      ex_imm_o      <= imm_i;
      ex_rs1_addr_o <= rs1_addr_i;
      ex_rs2_addr_o <= rs2_addr_i;
      ex_funct_o    <= funct_i;
      ex_RegDst_o   <= RegDst_i;
      ex_ALUOp_o    <= ALUOp_i;
      ex_ALUSrc_o   <= ALUSrc_i;
      ex_RegWrite_o <= RegWrite_i;
      ex_MemToReg_o <= MemToReg_i;
      ex_MemRead_o  <= MemRead_i;
      ex_MemWrite_o <= MemWrite_i;
      ex_valid_o    <= id_valid_i & ~hazard_o;
    end
  end

  // Saturating bubble counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      bubble_cnt_o <= '0;
    end else if (bubble_evt && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end

endmodule
